// File: rtl/bus_pkg.sv
// Shared types and default sizing for the register-transfer bus.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_NUM_REGS   = 4;

endpackage

// File: rtl/bus_mux.sv
// NUM_REGS:1 selector of DATA_WIDTH-bit words; an out-of-range select yields zero.
module bus_mux
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] data,
    input  logic [SEL_WIDTH-1:0]                sel,
    output logic [DATA_WIDTH-1:0]               y
);

    // Match-per-entry keeps NUM_REGS free of any power-of-two assumption.
    always_comb begin
        // NOTE: y gets a default before the loop so no path leaves it unassigned (no latch).
        y = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_WIDTH'(i)) y = data[i];
        end
    end

endmodule

// File: rtl/reg_transfer_bus.sv
// Register file with a three-state transfer engine: regs/ext -> bus_data -> regs.
// Optional per-register even parity is enabled by defining REG_TRANSFER_BUS_PARITY_EN.
module reg_transfer_bus
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_ext,
    input  logic [SEL_WIDTH-1:0]  req_src,
    input  logic [SEL_WIDTH-1:0]  req_dst,
    input  logic [DATA_WIDTH-1:0] ext_data,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  done,
    output logic                  err
);

    state_t state, state_nxt;

    logic                                 cap_ext;
    logic [SEL_WIDTH-1:0]                 cap_src;
    logic [SEL_WIDTH-1:0]                 cap_dst;
    logic [DATA_WIDTH-1:0]                cap_data;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [DATA_WIDTH-1:0]                src_data;
    logic                                 src_bad;
    logic                                 dst_bad;
    logic                                 par_bad;
    logic                                 read_fault;

    function automatic logic in_range(input logic [SEL_WIDTH-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == SEL_WIDTH'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    bus_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_src_mux (
        .data (regs),
        .sel  (cap_src),
        .y    (src_data)
    );

    bus_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_rd_mux (
        .data (regs),
        .sel  (rd_sel),
        .y    (rd_data)
    );

`ifdef REG_TRANSFER_BUS_PARITY_EN
    logic [NUM_REGS-1:0] par;
    logic                src_par;

    bus_mux #(
        .DATA_WIDTH (1),
        .NUM_REGS   (NUM_REGS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_par_mux (
        .data (par),
        .sel  (cap_src),
        .y    (src_par)
    );

    assign par_bad = !cap_ext && (src_par != ^src_data);
`else
    assign par_bad = 1'b0;
`endif

    assign src_bad    = !cap_ext && !in_range(cap_src);
    assign dst_bad    = !in_range(cap_dst);
    assign read_fault = src_bad || dst_bad || par_bad;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = READ;
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done/err are set on the READ->WRITE edge, so they are high exactly during WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap_ext  <= 1'b0;
            cap_src  <= '0;
            cap_dst  <= '0;
            cap_data <= '0;
            bus_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_ext  <= req_ext;
                        cap_src  <= req_src;
                        cap_dst  <= req_dst;
                        cap_data <= ext_data;
                    end
                end
                READ: begin
                    done     <= 1'b1;
                    err      <= read_fault;
                    bus_data <= read_fault ? '0 : (cap_ext ? cap_data : src_data);
                end
                default: ;
            endcase
        end
    end

    // err is high only during a faulted WRITE, so it doubles as the write veto.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is reset because software expects all-zero contents.
            regs <= '0;
`ifdef REG_TRANSFER_BUS_PARITY_EN
            par  <= '0;
`endif
        end else if (state == WRITE && !err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cap_dst == SEL_WIDTH'(i)) begin
                    regs[i] <= bus_data;
`ifdef REG_TRANSFER_BUS_PARITY_EN
                    par[i]  <= ^bus_data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_transfer_bus.sv
// Directed, table-driven bench for reg_transfer_bus (4-register and 3-register instances).
module tb_reg_transfer_bus;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ext = 1'b0;
    logic [1:0] req_src = '0;
    logic [1:0] req_dst = '0;
    logic [3:0] ext_data = '0;
    logic [1:0] rd_sel = '0;

    logic       req_ready, done, err;
    logic [3:0] rd_data, bus_data;
    logic       req_ready3, done3, err3;
    logic [3:0] rd_data3, bus_data3;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       ext;
        logic [1:0] src;
        logic [1:0] dst;
        logic [3:0] data;
        logic [3:0] exp_bus;
        logic [3:0] exp_bus3;
        logic       exp_err3;
    } vec_t;

    vec_t vecs [9];

    reg_transfer_bus #(.DATA_WIDTH(4), .NUM_REGS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ext   (req_ext),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .ext_data  (ext_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .bus_data  (bus_data),
        .done      (done),
        .err       (err)
    );

    reg_transfer_bus #(.DATA_WIDTH(4), .NUM_REGS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready3),
        .req_ext   (req_ext),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .ext_data  (ext_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data3),
        .bus_data  (bus_data3),
        .done      (done3),
        .err       (err3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Issues one request and returns while the block is in WRITE (done expected high).
    task automatic xfer(input logic ext, input logic [1:0] src, input logic [1:0] dst,
                        input logic [3:0] data);
        int lat;
        req_valid = 1'b1;
        req_ext   = ext;
        req_src   = src;
        req_dst   = dst;
        ext_data  = data;
        check("ready_idle", {31'd0, req_ready}, 1);
        tick();
        req_valid = 1'b0;
        req_ext   = ~ext;
        req_src   = ~src;
        req_dst   = ~dst;
        ext_data  = ~data;
        check("ready_read", {31'd0, req_ready}, 0);
        check("done_read", {31'd0, done}, 0);
        lat = 0;
        while (!done && lat < 6) begin
            tick();
            lat++;
        end
        check("latency", lat, 1);
        check("ready_write", {31'd0, req_ready}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 2'd0, 2'd2, 4'h9, 4'h9, 4'h9, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 2'd0, 4'h1, 4'h1, 4'h1, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 2'd1, 4'h2, 4'h2, 4'h2, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 2'd3, 4'hC, 4'h1, 4'h0, 1'b1};
        vecs[4] = '{1'b0, 2'd2, 2'd2, 4'hC, 4'h9, 4'h9, 1'b0};
        vecs[5] = '{1'b1, 2'd0, 2'd1, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[6] = '{1'b0, 2'd1, 2'd0, 4'h3, 4'hF, 4'hF, 1'b0};
        vecs[7] = '{1'b0, 2'd3, 2'd1, 4'h3, 4'h1, 4'h0, 1'b1};
        vecs[8] = '{1'b1, 2'd3, 2'd2, 4'h7, 4'h7, 4'h7, 1'b0};

        // Reset state
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check("reset_rd", {28'd0, rd_data}, 0);
        end
        check("reset_ready", {31'd0, req_ready}, 1);
        check("reset_bus", {28'd0, bus_data}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_err", {31'd0, err}, 0);
        rst = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].ext, vecs[i].src, vecs[i].dst, vecs[i].data);
            check("err", {31'd0, err}, 0);
            check("bus", {28'd0, bus_data}, {28'd0, vecs[i].exp_bus});
            check("done3", {31'd0, done3}, 1);
            check("err3", {31'd0, err3}, {31'd0, vecs[i].exp_err3});
            check("bus3", {28'd0, bus_data3}, {28'd0, vecs[i].exp_bus3});
            rd_sel = vecs[i].dst;
            #1;
            check("rd_before_commit", {28'd0, rd_data}, (i == 0) ? 32'h0 : {28'd0, rd_data});
            tick();
            check("done_clear", {31'd0, done}, 0);
            check("ready_after", {31'd0, req_ready}, 1);
            check("rd_after", {28'd0, rd_data}, {28'd0, vecs[i].exp_bus});
            if (i == 3) begin
                rd_sel = 2'd0;
                #1;
                check("src_unchanged", {28'd0, rd_data}, 32'h1);
            end
        end

        // Final register contents of both instances
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp4 [4];
            logic [3:0] exp3 [4];
            exp4 = '{4'hF, 4'h1, 4'h7, 4'h1};
            exp3 = '{4'hF, 4'hF, 4'h7, 4'h0};
            rd_sel = 2'(i);
            #1;
            check("final_rd", {28'd0, rd_data}, {28'd0, exp4[i]});
            check("final_rd3", {28'd0, rd_data3}, {28'd0, exp3[i]});
        end

        // Out-of-range destination on the 3-register instance
        xfer(1'b1, 2'd0, 2'd3, 4'h6);
        check("oor_done3", {31'd0, done3}, 1);
        check("oor_err3", {31'd0, err3}, 1);
        check("oor_bus3", {28'd0, bus_data3}, 0);
        check("oor_bus4", {28'd0, bus_data}, 32'h6);
        tick();
        check("oor_err3_clear", {31'd0, err3}, 0);
        rd_sel = 2'd2;
        #1;
        check("oor_r2_3", {28'd0, rd_data3}, 32'h7);
        rd_sel = 2'd1;
        #1;
        check("oor_r1_3", {28'd0, rd_data3}, 32'hF);
        rd_sel = 2'd3;
        #1;
        check("oor_rd3", {28'd0, rd_data3}, 0);
        check("r3_written", {28'd0, rd_data}, 32'h6);

        // bus_data holds between transfers
        tick();
        tick();
        tick();
        check("bus_hold", {28'd0, bus_data}, 32'h6);

        // Reset while in READ aborts the transfer
        req_valid = 1'b1;
        req_ext   = 1'b1;
        req_dst   = 2'd0;
        ext_data  = 4'hA;
        tick();
        req_valid = 1'b0;
        check("abort_in_read", {31'd0, req_ready}, 0);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, req_ready}, 1);
        check("abort_bus", {28'd0, bus_data}, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check("abort_rd", {28'd0, rd_data}, 0);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", {31'd0, done}, 0);
            tick();
        end
        rd_sel = 2'd0;
        #1;
        check("abort_r0", {28'd0, rd_data}, 0);

`ifdef REG_TRANSFER_BUS_PARITY_EN
        // Corrupted source parity blocks the write
        xfer(1'b1, 2'd0, 2'd1, 4'h3);
        tick();
        xfer(1'b1, 2'd0, 2'd0, 4'h5);
        tick();
        force dut.par[1] = 1'b1;
        xfer(1'b0, 2'd1, 2'd0, 4'h0);
        check("par_err", {31'd0, err}, 1);
        tick();
        release dut.par[1];
        rd_sel = 2'd0;
        #1;
        check("par_r0", {28'd0, rd_data}, 32'h5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
